// File: rtl/cycle_sequencer.sv
// Phase scheduler that sequences valve, drain and motor through FILL/WASH/RINSE/SPIN.
// Optional macro CYCLE_SEQUENCER_EXTRA_RINSE_EN doubles the RINSE phase in every program.
module cycle_sequencer #(
    parameter int FILL_T  = 4,
    parameter int WASH_T  = 8,
    parameter int RINSE_T = 6,
    parameter int SPIN_T  = 5,
    parameter int CW      = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          door_closed_i,
    input  logic          pause_btn_i,
    input  logic [1:0]    sel_i,
    output logic [2:0]    phase_o,
    output logic          valve_o,
    output logic          drain_o,
    output logic [1:0]    motor_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] remaining_o
);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_FILL  = 3'b001;
    localparam logic [2:0] S_WASH  = 3'b010;
    localparam logic [2:0] S_RINSE = 3'b011;
    localparam logic [2:0] S_SPIN  = 3'b100;
    localparam logic [2:0] S_DONE  = 3'b101;
    localparam logic [2:0] S_PAUSE = 3'b110;

    localparam logic [1:0] SEL_QUICK = 2'b01;
    localparam logic [1:0] SEL_RINSE = 2'b10;

    localparam int WASH_QT = ((WASH_T >> 1) > 0) ? (WASH_T >> 1) : 1;

    // Reload values are T-1 so that each phase spans exactly T cycles.
    localparam logic [CW-1:0] FILL_L  = CW'(FILL_T - 1);
    localparam logic [CW-1:0] WASH_L  = CW'(WASH_T - 1);
    localparam logic [CW-1:0] WASHQ_L = CW'(WASH_QT - 1);
    localparam logic [CW-1:0] RINSE_L = CW'(RINSE_T - 1);
    localparam logic [CW-1:0] SPIN_L  = CW'(SPIN_T - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    saved_q, saved_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          pause_q;
    logic          pedge;
`ifdef CYCLE_SEQUENCER_EXTRA_RINSE_EN
    logic          flag_q, flag_d;
`endif

    assign pedge = pause_btn_i & ~pause_q;

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
`ifdef CYCLE_SEQUENCER_EXTRA_RINSE_EN
        flag_d  = flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i && door_closed_i) begin
                    sel_d   = (sel_i == 2'b11) ? 2'b00 : sel_i;
                    state_d = S_FILL;
                    cnt_d   = FILL_L;
                end
            end
            S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                // Door open outranks the button, which outranks expiry; counter is held in PAUSE.
                if (!door_closed_i || pedge) begin
                    saved_d = state_q;
                    state_d = S_PAUSE;
                end else if (cnt_q == '0) begin
                    case (state_q)
                        S_FILL: begin
                            if (sel_q == SEL_RINSE) begin
                                state_d = S_RINSE;
                                cnt_d   = RINSE_L;
                            end else begin
                                state_d = S_WASH;
                                cnt_d   = (sel_q == SEL_QUICK) ? WASHQ_L : WASH_L;
                            end
                        end
                        S_WASH: begin
                            state_d = S_RINSE;
                            cnt_d   = RINSE_L;
                        end
                        S_RINSE: begin
`ifdef CYCLE_SEQUENCER_EXTRA_RINSE_EN
                            if (!flag_q) begin
                                flag_d = 1'b1;
                                cnt_d  = RINSE_L;
                            end else begin
                                flag_d  = 1'b0;
                                state_d = S_SPIN;
                                cnt_d   = SPIN_L;
                            end
`else
                            state_d = S_SPIN;
                            cnt_d   = SPIN_L;
`endif
                        end
                        default: begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PAUSE: begin
                if (pedge && door_closed_i) begin
                    state_d = saved_q;
                end
            end
            S_DONE: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            saved_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            pause_q <= 1'b0;
`ifdef CYCLE_SEQUENCER_EXTRA_RINSE_EN
            flag_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pause_q <= pause_btn_i;
`ifdef CYCLE_SEQUENCER_EXTRA_RINSE_EN
            flag_q  <= flag_d;
`endif
        end
    end

    always_comb begin
        phase_o     = state_q;
        valve_o     = 1'b0;
        drain_o     = 1'b0;
        motor_o     = 2'b00;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        remaining_o = '0;
        case (state_q)
            S_FILL: begin
                valve_o = 1'b1;
                busy_o  = 1'b1;
                remaining_o = cnt_q;
            end
            S_WASH: begin
                motor_o = 2'b01;
                busy_o  = 1'b1;
                remaining_o = cnt_q;
            end
            S_RINSE: begin
                valve_o = 1'b1;
                motor_o = 2'b01;
                busy_o  = 1'b1;
                remaining_o = cnt_q;
            end
            S_SPIN: begin
                drain_o = 1'b1;
                motor_o = 2'b10;
                busy_o  = 1'b1;
                remaining_o = cnt_q;
            end
            S_PAUSE: begin
                busy_o  = 1'b1;
                remaining_o = cnt_q;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed program runs plus random stimulus against a program-list model.
module tb_cycle_sequencer;

    localparam int FILL_T  = 4;
    localparam int WASH_T  = 8;
    localparam int RINSE_T = 6;
    localparam int SPIN_T  = 5;
    localparam int CW      = 4;
`ifdef CYCLE_SEQUENCER_EXTRA_RINSE_EN
    localparam int RINSE_PASSES = 2;
`else
    localparam int RINSE_PASSES = 1;
`endif
    localparam int WASH_Q = ((WASH_T / 2) > 0) ? (WASH_T / 2) : 1;
    localparam int SUM_N  = FILL_T + WASH_T + RINSE_T * RINSE_PASSES + SPIN_T;
    localparam int SUM_Q  = FILL_T + WASH_Q + RINSE_T * RINSE_PASSES + SPIN_T;
    localparam int SUM_R  = FILL_T + RINSE_T * RINSE_PASSES + SPIN_T;

    logic          clk = 1'b0;
    logic          reset, start, door, pbtn;
    logic [1:0]    sel;
    logic [2:0]    phase;
    logic          valve, drain, busy, done;
    logic [1:0]    motor;
    logic [CW-1:0] remaining;

    always #5 clk = ~clk;

    cycle_sequencer #(
        .FILL_T(FILL_T), .WASH_T(WASH_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T), .CW(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .door_closed_i(door),
        .pause_btn_i(pbtn), .sel_i(sel), .phase_o(phase), .valve_o(valve),
        .drain_o(drain), .motor_o(motor), .busy_o(busy), .done_o(done),
        .remaining_o(remaining)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Model: a program is a list of (phase code, length); mode 0 idle, 1 running, 2 paused, 3 done.
    int m_code[$];
    int m_len[$];
    int m_mode = 0;
    int m_idx  = 0;
    int m_left = 0;
    bit m_pq   = 1'b0;

    task automatic m_build(input logic [1:0] s);
        m_code.delete();
        m_len.delete();
        m_code.push_back(1); m_len.push_back(FILL_T);
        if (s == 2'b01) begin
            m_code.push_back(2); m_len.push_back(WASH_Q);
        end else if (s != 2'b10) begin
            m_code.push_back(2); m_len.push_back(WASH_T);
        end
        for (int i = 0; i < RINSE_PASSES; i++) begin
            m_code.push_back(3); m_len.push_back(RINSE_T);
        end
        m_code.push_back(4); m_len.push_back(SPIN_T);
    endtask

    task automatic m_step();
        bit pe;
        pe   = pbtn && !m_pq;
        m_pq = pbtn;
        if (reset) begin
            m_mode = 0;
            m_pq   = 1'b0;
            return;
        end
        case (m_mode)
            0: if (start && door) begin
                m_build(sel);
                m_idx  = 0;
                m_left = m_len[0] - 1;
                m_mode = 1;
            end
            1: begin
                if (!door || pe) m_mode = 2;
                else if (m_left == 0) begin
                    m_idx++;
                    if (m_idx >= m_code.size()) m_mode = 3;
                    else m_left = m_len[m_idx] - 1;
                end else m_left--;
            end
            2: if (pe && door) m_mode = 1;
            default: if (!start) m_mode = 0;
        endcase
    endtask

    function automatic int m_phase();
        case (m_mode)
            1: return m_code[m_idx];
            2: return 6;
            3: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int m_rem();
        return (m_mode == 1 || m_mode == 2) ? m_left : 0;
    endfunction

    // Packed as {valve, drain, motor[1:0], busy, done}.
    function automatic int m_act(input int code);
        case (code)
            1: return 6'b100010;
            2: return 6'b000110;
            3: return 6'b100110;
            4: return 6'b011010;
            5: return 6'b000001;
            6: return 6'b000010;
            default: return 0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
        chk("phase", int'(phase), m_phase());
        chk("outputs", int'({valve, drain, motor, busy, done}), m_act(m_phase()));
        chk("remaining", int'(remaining), m_rem());
    endtask

    task automatic run_prog(input logic [1:0] s, output int edges, output int busy_n, output bit saw_wash);
        sel = s; start = 1'b1; door = 1'b1;
        cyc();
        edges = 1;
        busy_n = busy ? 1 : 0;
        saw_wash = (phase == 3'b010);
        start = 1'b0;
        while (!done && edges < 200) begin
            cyc();
            edges++;
            if (busy) busy_n++;
            if (phase == 3'b010) saw_wash = 1'b1;
        end
    endtask

    task automatic wait_for(input int code, input int rem);
        int k;
        k = 0;
        while (!(int'(phase) == code && (rem < 0 || int'(remaining) == rem)) && k < 100) begin
            cyc();
            k++;
        end
        chk("wait_reached", int'(k < 100), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, b, n;
        bit w;
        reset = 1'b1; start = 1'b0; door = 1'b1; pbtn = 1'b0; sel = 2'b00;
        cyc(); cyc();
        chk("rst_phase", int'(phase), 0);
        chk("rst_outputs", int'({valve, drain, motor, busy, done, remaining}), 0);
        reset = 1'b0;
        cyc();

        run_prog(2'b00, e, b, w);
        chk("normal_done_edge", e, SUM_N + 1);
        chk("normal_busy", b, SUM_N);
        start = 1'b1;
        cyc(); cyc();
        chk("done_hold", int'(done), 1);
        start = 1'b0;
        cyc();
        chk("done_exit", int'(phase), 0);

        run_prog(2'b01, e, b, w);
        chk("quick_done_edge", e, SUM_Q + 1);
        cyc();
        run_prog(2'b10, e, b, w);
        chk("rinse_done_edge", e, SUM_R + 1);
        chk("rinse_no_wash", int'(w), 0);
        cyc();
        run_prog(2'b11, e, b, w);
        chk("sel3_done_edge", e, SUM_N + 1);
        cyc();

        sel = 2'b00; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_for(2, 5);
        pbtn = 1'b1; cyc(); pbtn = 1'b0;
        chk("pause_enter", int'(phase), 6);
        repeat (10) cyc();
        chk("pause_hold_rem", int'(remaining), 5);
        chk("pause_act_off", int'({valve, drain, motor}), 0);
        pbtn = 1'b1; cyc(); pbtn = 1'b0;
        chk("resume_phase", int'(phase), 2);
        chk("resume_rem", int'(remaining), 5);
        n = 0;
        while (phase == 3'b010 && n < 50) begin
            cyc();
            n++;
        end
        chk("resume_len", n, 6);
        wait_for(5, -1);
        cyc();

        start = 1'b1; cyc(); start = 1'b0;
        wait_for(4, -1);
        door = 1'b0; cyc();
        chk("door_pause", int'(phase), 6);
        chk("door_act_off", int'({drain, motor}), 0);
        pbtn = 1'b1; cyc(); pbtn = 1'b0; cyc();
        chk("door_open_btn", int'(phase), 6);
        door = 1'b1; cyc();
        pbtn = 1'b1; cyc(); pbtn = 1'b0;
        chk("door_resume", int'(phase), 4);
        wait_for(5, -1);
        cyc();

        door = 1'b0; start = 1'b1; cyc();
        chk("start_door_open", int'(phase), 0);
        door = 1'b1; start = 1'b0; cyc();

        start = 1'b1; cyc(); start = 1'b0;
        wait_for(2, -1);
        reset = 1'b1; cyc();
        chk("mid_reset_phase", int'(phase), 0);
        chk("mid_reset_outputs", int'({valve, drain, motor, busy, done, remaining}), 0);
        reset = 1'b0; cyc();

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(299) == 0);
            start = ($urandom_range(3) == 0);
            door  = ($urandom_range(15) != 0);
            if ($urandom_range(7) == 0) pbtn = ~pbtn;
            sel   = 2'($urandom_range(3));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
